mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle combinational sequencing with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It issues per-cycle enables for the PC, instruction register, register file and data memory, and selects the next-PC source. It sits between the instruction register / ALU flags and the existing datapath muxes, and waits on a ready handshake from data memory.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- run  in  1  1 = sequence instructions; 0 = stop at the next instruction boundary
- op  in  6  opcode from the instruction register (instr[31:26])
- funct  in  6  function field (instr[5:0])
- zero  in  1  ALU result == 0, valid in the BRANCH state
- mem_rdy  in  1  data-memory access complete
- pc_wr  out  1  load PC this cycle
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target {PC[31:28],instr[25:0],00}, 3 = rs (jr)
- ir_wr  out  1  latch the instruction register
- reg_wr  out  1  register-file write enable
- mem_rd  out  1  data-memory read request
- mem_wr  out  1  data-memory write request
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky flag: an unsupported opcode was decoded
- instr_cnt  out  CNT_W  count of retired instructions

## Operation
Supported opcodes:
- R-type 000000: funct 001000 = jr; any other funct = ALU operation
- lw 100011, sw 101011
- beq 000100, bne 000101
- j 000010, jal 000011
- addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, lui 001111
- Any other opcode is illegal.

State encodings:
- IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7, HALT=8

Transitions and outputs (any output not listed is 0):
- IDLE: if run=1, go to FETCH.
- FETCH: ir_wr=1; go to DECODE.
- DECODE:
  - illegal opcode: set illegal, go to HALT
  - j, jal or jr: go to JUMP
  - beq or bne: go to BRANCH
  - otherwise: go to EXEC
- EXEC: lw or sw go to MEM; all others go to WB.
- MEM: hold mem_rd=1 (lw) or mem_wr=1 (sw) until mem_rdy=1.
  - lw: go to WB
  - sw: retire
- WB: reg_wr=1, pc_wr=1, pc_src=0; retire.
- BRANCH: pc_wr=1. Taken = (beq & zero) | (bne & ~zero). pc_src=1 if taken, else 0. Retire.
- JUMP: pc_wr=1. pc_src=3 for jr, else 2. reg_wr=1 for jal only (the datapath selects $31 and PC+4). Retire.
- sw retire (the MEM cycle with mem_rdy=1) also asserts pc_wr=1, pc_src=0.
- Retire: instr_cnt increments by 1 (wraps modulo 2^CNT_W). Next state is FETCH if run=1, else IDLE.
- HALT: absorbing; all enables 0. Only reset leaves HALT.

## Timing
- Reset values: state=IDLE, illegal=0, instr_cnt=0; all enables 0 and pc_src=0.
- Reset is asynchronous. Asserting rst mid-MEM drops mem_rd/mem_wr immediately, with no retire.
- Enables decode combinationally from the registered state. pc_src/pc_wr in BRANCH depend on zero; in MEM they depend on mem_rdy.
- Cycles per instruction, counting FETCH through retire, with zero-wait memory (mem_rdy already 1 in MEM):
  - R-type and I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq, bne, j, jal, jr: 3
  - Each cycle with mem_rdy=0 in MEM adds 1.
- mem_rdy is ignored outside MEM.
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction completes that instruction.
- illegal is set on the DECODE→HALT edge. instr_cnt does not increment for the illegal instruction.

## Structure
- Shared package holds:
  - state encoding constants
  - opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, FN_JR)
  - PC_SRC_* constants
- One sub-module, mc_decode: combinational classifier (op, funct) → {is_alu, is_lw, is_sw, is_br, is_jmp, is_jal, is_jr, is_illegal}.
- mc_sequencer holds the state register, the illegal flag, instr_cnt and the output decode.

## Test plan
- Reset then run=1, feed addi (op=001000), mem_rdy=0 → states 1,2,3,5; reg_wr and pc_wr high only in WB; instr_cnt=1; state returns to FETCH.
- lw with mem_rdy low for 3 MEM cycles, then high → mem_rd held 4 cycles; WB follows with reg_wr=1; 8 cycles total; instr_cnt +1.
- beq with zero=1 → pc_src=1, pc_wr=1 in BRANCH. bne with zero=1 → pc_src=0. jr (op=0, funct=001000) → JUMP with pc_src=3, reg_wr=0. jal → pc_src=2, reg_wr=1.
- op=111111 → illegal=1, state=8 thereafter; no enables while run=1 for 20 cycles; instr_cnt unchanged.
- sw in MEM with mem_rdy=0, then rst pulled low → mem_wr drops in the same cycle; state=0; instr_cnt=0; illegal=0.
- run dropped during EXEC of an R-type → instruction retires through WB, then state=IDLE; run=1 resumes with FETCH the next cycle.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: state codes,
// opcode/funct values and next-PC source selects.
package mc_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;
    localparam logic [1:0] PC_SRC_JR  = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps (op, funct) onto the instruction
// classes the sequencer steps through.
module mc_decode
    import mc_sequencer_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       is_alu,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_br,
    output logic       is_jmp,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_illegal
);

    always_comb begin
        is_alu     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_br      = 1'b0;
        is_jmp     = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    is_jmp = 1'b1;
                    is_jr  = 1'b1;
                end else begin
                    is_alu = 1'b1;
                end
            end
            OP_LW:          is_lw = 1'b1;
            OP_SW:          is_sw = 1'b1;
            OP_BEQ, OP_BNE: is_br = 1'b1;
            OP_J:           is_jmp = 1'b1;
            OP_JAL: begin
                is_jmp = 1'b1;
                is_jal = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: is_alu = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives the datapath enables.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_reg, state_next;
    logic             illegal_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             retire;
    logic             set_illegal;
    logic             br_taken;

    logic is_alu, is_lw, is_sw, is_br, is_jmp, is_jal, is_jr, is_illegal;

    mc_decode u_decode (
        .op         (op),
        .funct      (funct),
        .is_alu     (is_alu),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_br      (is_br),
        .is_jmp     (is_jmp),
        .is_jal     (is_jal),
        .is_jr      (is_jr),
        .is_illegal (is_illegal)
    );

    // beq is taken on zero, bne on non-zero
    assign br_taken = is_br && (zero ^ (op == OP_BNE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (retire)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_wr       = 1'b0;
        pc_src      = PC_SRC_PC4;
        ir_wr       = 1'b0;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_wr      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_illegal) begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end else if (is_jmp) begin
                    state_next = S_JUMP;
                end else if (is_br) begin
                    state_next = S_BRANCH;
                end else if (is_alu || is_lw || is_sw) begin
                    state_next = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_EXEC: begin
                state_next = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_wr = is_sw;
                mem_rd = !is_sw;
                if (mem_rdy) begin
                    if (is_sw) begin
                        pc_wr  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                pc_wr  = 1'b1;
                pc_src = br_taken ? PC_SRC_BR : PC_SRC_PC4;
                retire = 1'b1;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = is_jr ? PC_SRC_JR : PC_SRC_JMP;
                reg_wr = is_jal;
                retire = 1'b1;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        // run is only looked at on the instruction boundary
        if (retire)
            state_next = run ? S_FETCH : S_IDLE;
    end

    assign state     = state_reg;
    assign illegal   = illegal_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed cases plus random instruction
// streams compared cycle by cycle against a per-instruction schedule model.
module tb_mc_sequencer;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3, ST_MEM = 4;
    localparam int ST_WB = 5, ST_BRANCH = 6, ST_JUMP = 7, ST_HALT = 8;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_JAL = 5, K_JR = 6, K_ILL = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        ir_wr;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_ill = 1'b0;

    mc_sequencer #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_rdy   (mem_rdy),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .ir_wr     (ir_wr),
        .reg_wr    (reg_wr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .state     (state),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // enable vector packing: {pc_wr, pc_src[1:0], ir_wr, reg_wr, mem_rd, mem_wr}
    function automatic logic [6:0] mk_en(input logic pw, input logic [1:0] ps, input logic iw,
                                         input logic rw, input logic mr, input logic mw);
        return {pw, ps, iw, rw, mr, mw};
    endfunction

    task automatic check_cycle(input string tag, input int exp_state, input logic [6:0] exp_en);
        check({tag, " state"}, {28'd0, state}, exp_state);
        check({tag, " enables"}, {25'd0, pc_wr, pc_src, ir_wr, reg_wr, mem_rd, mem_wr}, {25'd0, exp_en});
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        check({tag, " instr_cnt"}, instr_cnt, exp_cnt);
    endtask

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: return (f == 6'b001000) ? K_JR : K_ALU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100, 6'b000101: return K_BR;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001111: return K_ALU;
            default:   return K_ILL;
        endcase
    endfunction

    // mode: 0 = run random mid-instruction, 1 = run held high, 2 = run dropped from EXEC on
    task automatic do_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int waits, input logic run_after, input int mode);
        int          st_q[$];
        logic [6:0]  en_q[$];
        logic        rdy_q[$];
        int          k;
        logic        taken;
        k = kind_of(o, f);
        st_q.push_back(ST_FETCH);  en_q.push_back(mk_en(0, 2'd0, 1, 0, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1)));
        st_q.push_back(ST_DECODE); en_q.push_back(7'd0);                       rdy_q.push_back(1'($urandom_range(0, 1)));
        case (k)
            K_ALU: begin
                st_q.push_back(ST_EXEC); en_q.push_back(7'd0); rdy_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(ST_WB); en_q.push_back(mk_en(1, 2'd0, 0, 1, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1)));
            end
            K_LW: begin
                st_q.push_back(ST_EXEC); en_q.push_back(7'd0); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int w = 0; w <= waits; w++) begin
                    st_q.push_back(ST_MEM); en_q.push_back(mk_en(0, 2'd0, 0, 0, 1, 0)); rdy_q.push_back(w == waits);
                end
                st_q.push_back(ST_WB); en_q.push_back(mk_en(1, 2'd0, 0, 1, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1)));
            end
            K_SW: begin
                st_q.push_back(ST_EXEC); en_q.push_back(7'd0); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int w = 0; w <= waits; w++) begin
                    st_q.push_back(ST_MEM);
                    en_q.push_back(mk_en(w == waits, 2'd0, 0, 0, 0, 1));
                    rdy_q.push_back(w == waits);
                end
            end
            K_BR: begin
                taken = (o == 6'b000100) ? z : !z;
                st_q.push_back(ST_BRANCH); en_q.push_back(mk_en(1, taken ? 2'd1 : 2'd0, 0, 0, 0, 0));
                rdy_q.push_back(1'($urandom_range(0, 1)));
            end
            K_J:   begin st_q.push_back(ST_JUMP); en_q.push_back(mk_en(1, 2'd2, 0, 0, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1))); end
            K_JAL: begin st_q.push_back(ST_JUMP); en_q.push_back(mk_en(1, 2'd2, 0, 1, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1))); end
            K_JR:  begin st_q.push_back(ST_JUMP); en_q.push_back(mk_en(1, 2'd3, 0, 0, 0, 0)); rdy_q.push_back(1'($urandom_range(0, 1))); end
            default: ;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            @(negedge clk);
            op = o; funct = f; zero = z; mem_rdy = rdy_q[i];
            if (i == st_q.size() - 1) run = run_after;
            else if (mode == 2 && i >= 2) run = 1'b0;
            else if (mode == 1) run = 1'b1;
            else run = 1'($urandom_range(0, 1));
            #1;
            check_cycle($sformatf("%s c%0d", tag, i), st_q[i], en_q[i]);
        end
        if (k == K_ILL) exp_ill = 1'b1;
        else exp_cnt = exp_cnt + 32'd1;
        $display("instr %s op=%b funct=%b zero=%0d waits=%0d cycles=%0d cnt=%0d",
                 tag, o, f, z, waits, st_q.size(), exp_cnt);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run = 1'b0; mem_rdy = 1'($urandom_range(0, 1));
            #1;
            check_cycle("idle", ST_IDLE, 7'd0);
        end
        @(negedge clk);
        run = 1'b1;
        #1;
        check_cycle("idle_go", ST_IDLE, 7'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_cnt = 32'd0;
        exp_ill = 1'b0;
        check_cycle(tag, ST_IDLE, 7'd0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
    endtask

    logic [5:0] legal_ops [14] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001001,
                                   6'b001010, 6'b001100, 6'b001101, 6'b001111};

    initial begin
        logic [5:0] ro, rf;
        logic       ra;
        repeat (2) @(negedge clk);
        #1;
        check_cycle("reset", ST_IDLE, 7'd0);
        rst = 1'b1;

        idle_cycles(1);
        do_instr("addi", 6'b001000, 6'd0, 1'b0, 0, 1'b1, 1);
        do_instr("lw_wait3", 6'b100011, 6'd0, 1'b0, 3, 1'b1, 1);
        do_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 0, 1'b1, 1);
        do_instr("bne_z1", 6'b000101, 6'd0, 1'b1, 0, 1'b1, 1);
        do_instr("bne_z0", 6'b000101, 6'd0, 1'b0, 0, 1'b1, 1);
        do_instr("jr", 6'b000000, 6'b001000, 1'b0, 0, 1'b1, 1);
        do_instr("jal", 6'b000011, 6'd0, 1'b0, 0, 1'b1, 1);
        do_instr("j", 6'b000010, 6'd0, 1'b0, 0, 1'b1, 1);
        do_instr("sw_wait2", 6'b101011, 6'd0, 1'b0, 2, 1'b1, 1);
        do_instr("rtype_drop", 6'b000000, 6'b100000, 1'b0, 0, 1'b0, 2);
        idle_cycles(0);

        for (int n = 0; n < 150; n++) begin
            ro = legal_ops[$urandom_range(0, 13)];
            rf = 6'($urandom);
            if (ro == 6'd0 && $urandom_range(0, 3) == 0) rf = 6'b001000;
            ra = (n == 149) ? 1'b0 : ($urandom_range(0, 3) != 0);
            do_instr($sformatf("rnd%0d", n), ro, rf, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), ra, 0);
            if (!ra) idle_cycles($urandom_range(0, 2));
        end

        // sw stalled in MEM, then asynchronous reset before the next edge
        @(negedge clk); op = 6'b101011; mem_rdy = 1'b0; run = 1'b1; #1;
        check_cycle("swrst F", ST_FETCH, mk_en(0, 2'd0, 1, 0, 0, 0));
        @(negedge clk); #1;
        check_cycle("swrst D", ST_DECODE, 7'd0);
        @(negedge clk); #1;
        check_cycle("swrst E", ST_EXEC, 7'd0);
        @(negedge clk); #1;
        check_cycle("swrst M", ST_MEM, mk_en(0, 2'd0, 0, 0, 0, 1));
        #2 rst = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check_cycle("swrst async", ST_IDLE, 7'd0);
        $display("reset during sw MEM: state=%0d mem_wr=%0d cnt=%0d", state, mem_wr, instr_cnt);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;

        idle_cycles(1);
        do_instr("addi2", 6'b001000, 6'd0, 1'b0, 0, 1'b1, 1);
        do_instr("illegal", 6'b111111, 6'd0, 1'b0, 0, 1'b1, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = 1'b1; mem_rdy = 1'($urandom_range(0, 1)); op = 6'($urandom);
            #1;
            check_cycle("halt", ST_HALT, 7'd0);
        end
        $display("halt held 20 cycles: state=%0d illegal=%0d cnt=%0d", state, illegal, instr_cnt);

        do_reset("final_reset");
        idle_cycles(0);
        do_instr("post_halt_ori", 6'b001101, 6'd0, 1'b0, 0, 1'b0, 1);
        @(negedge clk); run = 1'b0; #1;
        check_cycle("end_idle", ST_IDLE, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
